// File: rtl/tpg_pkg.sv
// Shared encodings for the test pattern generator: mode codes, colour-bar
// channel masks and FSM states.
package tpg_pkg;

    localparam logic [1:0] MODE_SOLID    = 2'd0;
    localparam logic [1:0] MODE_BARS     = 2'd1;
    localparam logic [1:0] MODE_CHECKER  = 2'd2;
    localparam logic [1:0] MODE_GRADIENT = 2'd3;

    // Bit k set means the channel is full-scale in bar k
    // (white, yellow, cyan, green, magenta, red, blue, black).
    localparam logic [7:0] BAR_R_MASK = 8'b0011_0011;
    localparam logic [7:0] BAR_G_MASK = 8'b0000_1111;
    localparam logic [7:0] BAR_B_MASK = 8'b0101_0101;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/tpg_pixel_color.sv
// Combinational pixel colour: maps a raster position and the frame's latched
// mode/solid colour to one RGB triple.
module tpg_pixel_color
    import tpg_pkg::*;
#(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int COLOR_BITS = 4,
    parameter int CHECK_LOG2 = 5,
    localparam int XW = $clog2(H_ACTIVE),
    localparam int YW = $clog2(V_ACTIVE)
) (
    input  logic [XW-1:0]           x,
    input  logic [YW-1:0]           y,
    input  logic [1:0]              mode,
    input  logic [3*COLOR_BITS-1:0] solid_rgb,
    output logic [COLOR_BITS-1:0]   r,
    output logic [COLOR_BITS-1:0]   g,
    output logic [COLOR_BITS-1:0]   b
);

    localparam logic [COLOR_BITS-1:0] FULL = {COLOR_BITS{1'b1}};

    logic [XW+2:0]         x8;
    logic [2:0]            bar;
    logic                  check_odd;
    logic [COLOR_BITS-1:0] grad_r;

    // Bar index is the largest k with k*H_ACTIVE <= 8*x, kept in XW+3 bits.
    always_comb begin
        x8  = {x, 3'b000};
        bar = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (x8 >= (XW+3)'(k * H_ACTIVE))
                bar = 3'(k);
        end
    end

    assign check_odd = 1'(x >> CHECK_LOG2) ^ 1'(y >> CHECK_LOG2);
    assign grad_r    = COLOR_BITS'({x, {COLOR_BITS{1'b0}}} >> XW);

    always_comb begin
        r = '0;
        g = '0;
        b = '0;
        case (mode)
            MODE_SOLID: begin
                r = solid_rgb[3*COLOR_BITS-1 -: COLOR_BITS];
                g = solid_rgb[2*COLOR_BITS-1 -: COLOR_BITS];
                b = solid_rgb[COLOR_BITS-1:0];
            end
            MODE_BARS: begin
                r = BAR_R_MASK[bar] ? FULL : '0;
                g = BAR_G_MASK[bar] ? FULL : '0;
                b = BAR_B_MASK[bar] ? FULL : '0;
            end
            MODE_CHECKER: begin
                r = check_odd ? '0 : FULL;
                g = check_odd ? '0 : FULL;
                b = check_odd ? '0 : FULL;
            end
            default: begin
                r = grad_r;
                g = COLOR_BITS'({y, {COLOR_BITS{1'b0}}} >> YW);
                b = ~grad_r;
            end
        endcase
    end

endmodule

// File: rtl/test_pattern_gen.sv
// Streamed raster test-pattern source: one pixel per valid/ready beat in
// raster order, with mode and solid colour latched at each frame start.
module test_pattern_gen
    import tpg_pkg::*;
#(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int COLOR_BITS = 4,
    parameter int CHECK_LOG2 = 5,
    localparam int XW = $clog2(H_ACTIVE),
    localparam int YW = $clog2(V_ACTIVE)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [1:0]              mode,
    input  logic [3*COLOR_BITS-1:0] solid_rgb,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [COLOR_BITS-1:0]   r_out,
    output logic [COLOR_BITS-1:0]   g_out,
    output logic [COLOR_BITS-1:0]   b_out,
    output logic [XW-1:0]           x_out,
    output logic [YW-1:0]           y_out,
    output logic                    sof,
    output logic                    eol,
    output logic                    frame_done
);

    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

    state_t state_q, state_nx;

    logic                    vld_p0, sof_p0, eol_p0, done_p0;
    logic [XW-1:0]           x_p0;
    logic [YW-1:0]           y_p0;
    logic [COLOR_BITS-1:0]   r_p0, g_p0, b_p0;
    logic [1:0]              mode_p0;
    logic [3*COLOR_BITS-1:0] solid_p0;

    logic                    beat, last_px, start, advance;
    logic                    vld_nx, done_nx;
    logic [XW-1:0]           x_nx;
    logic [YW-1:0]           y_nx;
    logic [1:0]              mode_nx;
    logic [3*COLOR_BITS-1:0] solid_nx;
    logic [COLOR_BITS-1:0]   r_nx, g_nx, b_nx;

    assign beat    = vld_p0 & out_ready;
    assign last_px = (x_p0 == X_LAST) && (y_p0 == Y_LAST);

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_nx;
    end

    always_comb begin
        state_nx = state_q;
        case (state_q)
            IDLE:    if (enable) state_nx = RUN;
            RUN:     if (beat && last_px && !enable) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Next raster position and frame settings; a new frame starts either from
    // IDLE or directly after the last pixel when enable is still high.
    always_comb begin
        start    = ((state_q == IDLE) && enable) ||
                   ((state_q == RUN) && beat && last_px && enable);
        advance  = (state_q == RUN) && beat && !last_px;
        done_nx  = (state_q == RUN) && beat && last_px;
        x_nx     = x_p0;
        y_nx     = y_p0;
        mode_nx  = mode_p0;
        solid_nx = solid_p0;
        vld_nx   = vld_p0;
        if (start) begin
            x_nx     = '0;
            y_nx     = '0;
            mode_nx  = mode;
            solid_nx = solid_rgb;
            vld_nx   = 1'b1;
        end else if (advance) begin
            if (x_p0 == X_LAST) begin
                x_nx = '0;
                y_nx = y_p0 + 1'b1;
            end else begin
                x_nx = x_p0 + 1'b1;
            end
        end else if (done_nx) begin
            vld_nx = 1'b0;
        end
    end

    tpg_pixel_color #(
        .H_ACTIVE   (H_ACTIVE),
        .V_ACTIVE   (V_ACTIVE),
        .COLOR_BITS (COLOR_BITS),
        .CHECK_LOG2 (CHECK_LOG2)
    ) u_color (
        .x         (x_nx),
        .y         (y_nx),
        .mode      (mode_nx),
        .solid_rgb (solid_nx),
        .r         (r_nx),
        .g         (g_nx),
        .b         (b_nx)
    );

    // Stage p0: registered pixel, position and markers presented downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0   <= 1'b0;
            x_p0     <= '0;
            y_p0     <= '0;
            r_p0     <= '0;
            g_p0     <= '0;
            b_p0     <= '0;
            sof_p0   <= 1'b0;
            eol_p0   <= 1'b0;
            done_p0  <= 1'b0;
            mode_p0  <= MODE_SOLID;
            solid_p0 <= '0;
        end else begin
            vld_p0   <= vld_nx;
            x_p0     <= x_nx;
            y_p0     <= y_nx;
            r_p0     <= r_nx;
            g_p0     <= g_nx;
            b_p0     <= b_nx;
            sof_p0   <= vld_nx && (x_nx == '0) && (y_nx == '0);
            eol_p0   <= vld_nx && (x_nx == X_LAST);
            done_p0  <= done_nx;
            mode_p0  <= mode_nx;
            solid_p0 <= solid_nx;
        end
    end

    assign out_valid  = vld_p0;
    assign r_out      = r_p0;
    assign g_out      = g_p0;
    assign b_out      = b_p0;
    assign x_out      = x_p0;
    assign y_out      = y_p0;
    assign sof        = sof_p0;
    assign eol        = eol_p0;
    assign frame_done = done_p0;

endmodule

// File: tb/tb_test_pattern_gen.sv
// Scoreboard bench for test_pattern_gen on an 8x4 raster: expected pixels are
// queued when a frame's settings are driven and compared on every beat.
module tb_test_pattern_gen;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int CB = 4;
    localparam int CL = 1;
    localparam int XW = 3;
    localparam int YW = 2;

    logic          clk = 1'b0;
    logic          rst, enable, out_ready;
    logic [1:0]    mode;
    logic [11:0]   solid_rgb;
    logic          out_valid, sof, eol, frame_done;
    logic [3:0]    r_out, g_out, b_out;
    logic [XW-1:0] x_out;
    logic [YW-1:0] y_out;

    test_pattern_gen #(
        .H_ACTIVE   (H),
        .V_ACTIVE   (V),
        .COLOR_BITS (CB),
        .CHECK_LOG2 (CL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .mode       (mode),
        .solid_rgb  (solid_rgb),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .r_out      (r_out),
        .g_out      (g_out),
        .b_out      (b_out),
        .x_out      (x_out),
        .y_out      (y_out),
        .sof        (sof),
        .eol        (eol),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [11:0]   rgb;
        logic          sof;
        logic          eol;
        logic          last;
    } pix_t;

    pix_t        q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          beats = 0;
    int          c31 = 0;
    int          c32 = 0;
    int          rdy_pat = 0;
    logic        done_pend = 1'b0;
    logic        hold_prev = 1'b0;
    logic [19:0] snap = '0;

    function automatic logic [11:0] model(logic [1:0] m, logic [11:0] s, int x, int y);
        int k;
        logic [3:0] r, g, b;
        case (m)
            2'd0: return s;
            2'd1: begin
                k = (x * 8) / H;
                r = (k inside {0, 1, 4, 5}) ? 4'hF : 4'h0;
                g = (k < 4) ? 4'hF : 4'h0;
                b = (k % 2 == 0) ? 4'hF : 4'h0;
                return {r, g, b};
            end
            2'd2: return ((((x >> CL) ^ (y >> CL)) & 1) != 0) ? 12'h000 : 12'hFFF;
            default: begin
                r = 4'((x << CB) >> XW);
                g = 4'((y << CB) >> YW);
                b = ~r;
                return {r, g, b};
            end
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [1:0] m, input logic [11:0] s);
        for (int yy = 0; yy < V; yy++) begin
            for (int xx = 0; xx < H; xx++) begin
                pix_t p;
                p.x    = XW'(xx);
                p.y    = YW'(yy);
                p.rgb  = model(m, s, xx, yy);
                p.sof  = (xx == 0) && (yy == 0);
                p.eol  = (xx == H - 1);
                p.last = (xx == H - 1) && (yy == V - 1);
                q.push_back(p);
            end
        end
    endtask

    // One clock: drive ready, check frame_done and stall stability, score a beat.
    task automatic step();
        logic [19:0] now;
        pix_t p;
        cyc++;
        out_ready = (rdy_pat == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
        chk("frame_done", 32'(frame_done), 32'(done_pend));
        done_pend = 1'b0;
        now = {out_valid, x_out, y_out, r_out, g_out, b_out, sof, eol};
        if (hold_prev)
            chk("stall_hold", 32'(now), 32'(snap));
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_beat", 32'(beats), 32'hFFFF_FFFF);
            end else begin
                p = q.pop_front();
                chk("pixel", 32'({x_out, y_out, r_out, g_out, b_out, sof, eol}),
                    32'({p.x, p.y, p.rgb, p.sof, p.eol}));
                done_pend = p.last;
            end
            if (beats == 31) c31 = cyc;
            if (beats == 32) c32 = cyc;
            beats++;
        end
        hold_prev = out_valid && !out_ready;
        snap      = now;
        @(negedge clk);
    endtask

    task automatic run_until(input int n);
        int budget = 0;
        while (beats < n && budget < 400) begin
            step();
            budget++;
        end
        chk("beat_count", 32'(beats), 32'(n));
    endtask

    initial begin
        rst       = 1'b1;
        enable    = 1'b0;
        mode      = 2'd0;
        solid_rgb = 12'h000;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_rgb",   32'({r_out, g_out, b_out}), 0);
        chk("rst_xy",    32'({x_out, y_out}), 0);
        chk("rst_marks", 32'({sof, eol, frame_done}), 0);

        // Frame 1: SOLID red, full throughput.
        rst       = 1'b0;
        enable    = 1'b1;
        mode      = 2'd0;
        solid_rgb = 12'hF00;
        push_frame(2'd0, 12'hF00);
        @(negedge clk);
        chk("start_valid", 32'(out_valid), 1);
        chk("start_sof",   32'(sof), 1);

        // Mid-frame switch to CHECKER only takes effect on frame 2.
        run_until(10);
        mode = 2'd2;
        push_frame(2'd2, 12'hF00);
        run_until(33);
        chk("no_gap", 32'(c32 - c31), 1);

        // Frame 3: BARS under 1,0,0,1 backpressure.
        run_until(40);
        mode = 2'd1;
        push_frame(2'd1, 12'hF00);
        run_until(60);
        rdy_pat = 1;

        // Frame 4: GRADIENT; enable dropped early, frame must still finish.
        run_until(70);
        mode = 2'd3;
        solid_rgb = 12'h0F0;
        push_frame(2'd3, 12'hF00);
        run_until(96);
        rdy_pat = 0;
        run_until(101);
        enable = 1'b0;
        run_until(128);
        chk("end_valid", 32'(out_valid), 0);
        repeat (3) step();
        chk("idle_valid", 32'(out_valid), 0);
        chk("idle_beats", 32'(beats), 128);

        // Frame 5: restart from IDLE, then reset mid-frame.
        enable    = 1'b1;
        mode      = 2'd0;
        solid_rgb = 12'h5A3;
        push_frame(2'd0, 12'h5A3);
        @(negedge clk);
        chk("restart_valid", 32'(out_valid), 1);
        chk("restart_sof",   32'(sof), 1);
        run_until(141);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_valid", 32'(out_valid), 0);
        chk("mrst_xy",    32'({x_out, y_out}), 0);
        chk("mrst_rgb",   32'({r_out, g_out, b_out}), 0);
        chk("mrst_done",  32'(frame_done), 0);
        rst       = 1'b0;
        enable    = 1'b0;
        q.delete();
        hold_prev = 1'b0;
        done_pend = 1'b0;
        repeat (3) step();
        chk("post_rst_beats", 32'(beats), 141);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
